seqdet_match_monitor: RTL

Downstream consumer of the serial sequence detector's one-cycle match pulse. Counts matches, measures the enabled-cycle gap between consecutive matches, and on request serializes a snapshot of both values onto a single output pin. Sits directly behind the detector in the same Tiny Tapeout tile, so results leave on one data pin plus a valid strobe.

---
 rtl/seqdet_pkg.sv | 18 +
 rtl/seqdet_match_monitor_if.sv | 30 +++
 rtl/seqdet_snap_shifter.sv | 74 +++++++
 rtl/seqdet_match_monitor.sv | 106 ++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared types and default widths for the sequence detector tile.
// No logic; parameters and state encodings only.
// Not applicable (no datapath).
package seqdet_pkg;
    localparam int CNT_W_DEF = 8;
    localparam int GAP_W_DEF = 8;
    localparam int SNAP_W    = CNT_W_DEF + GAP_W_DEF;

    typedef enum logic {
        TRK_EMPTY = 1'b0,
        TRK_TRACK = 1'b1
    } trk_state_e;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_SHIFT = 1'b1
    } rd_state_e;
endpackage

// File: rtl/seqdet_match_monitor_if.sv
// Bundle of control inputs and result outputs of the match monitor.
// Wires only, no latency.
// ena is the only stall control; there is no ready path back to the detector.
interface seqdet_match_monitor_if
    import seqdet_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
);
    logic             ena;
    logic             match_in;
    logic             clear;
    logic             snap_req;
    logic [CNT_W-1:0] match_count;
    logic [GAP_W-1:0] gap_last;
    logic             overflow;
    logic             busy;
    logic             ser_out;
    logic             ser_valid;

    modport master (
        output ena, match_in, clear, snap_req,
        input  match_count, gap_last, overflow, busy, ser_out, ser_valid
    );

    modport slave (
        input  ena, match_in, clear, snap_req,
        output match_count, gap_last, overflow, busy, ser_out, ser_valid
    );
endinterface

// File: rtl/seqdet_snap_shifter.sv
// Parallel-load MSB-first shifter with IDLE/SHIFT readout FSM and bit counter.
// First bit on ser_out the cycle after load is sampled; W bits over W enabled cycles.
// ena low stalls the shift and masks ser_valid; load while shifting is ignored.
module seqdet_snap_shifter
    import seqdet_pkg::*;
#(
    parameter int W = SNAP_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ena,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         busy
);
    localparam int BCW = $clog2(W + 1);

    rd_state_e      state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0] bcnt_q,  bcnt_d;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RD_IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Next state: clear aborts, load only accepted from IDLE, one bit per enabled cycle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        if (clear) begin
            state_d = RD_IDLE;
            shreg_d = '0;
            bcnt_d  = '0;
        end else if (ena) begin
            case (state_q)
                RD_IDLE: begin
                    if (load) begin
                        state_d = RD_SHIFT;
                        shreg_d = din;
                        bcnt_d  = BCW'(W);
                    end
                end
                RD_SHIFT: begin
                    shreg_d = shreg_q << 1;
                    bcnt_d  = bcnt_q - BCW'(1);
                    if (bcnt_q == BCW'(1)) begin
                        state_d = RD_IDLE;
                    end
                end
                default: state_d = RD_IDLE;
            endcase
        end
    end

    // Outputs: the register MSB is the pending bit; it shifts to zero by the end of a readout.
    always_comb begin
        busy      = (state_q == RD_SHIFT);
        ser_valid = busy & ena;
        ser_out   = shreg_q[W-1];
    end
endmodule

// File: rtl/seqdet_match_monitor.sv
// Counts detector matches, tracks gap between the last two, serializes a snapshot on request.
// Counters update one cycle after match_in; readout starts the cycle after snap_req.
// ena low freezes everything except clear; snap_req during a readout is dropped.
module seqdet_match_monitor
    import seqdet_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    seqdet_match_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [GAP_W-1:0] GAP_MAX = '1;

    trk_state_e       trk_q, trk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0] gap_last_q, gap_last_d;
    logic             ovf_q, ovf_d;

    // Tracker state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) trk_q <= TRK_EMPTY;
        else       trk_q <= trk_d;
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            gap_cnt_q  <= '0;
            gap_last_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            gap_last_q <= gap_last_d;
            ovf_q      <= ovf_d;
        end
    end

    // Tracker next state: first match after reset/clear starts tracking.
    always_comb begin
        trk_d = trk_q;
        if (bus.clear) begin
            trk_d = TRK_EMPTY;
        end else if (bus.ena && bus.match_in) begin
            trk_d = TRK_TRACK;
        end
    end

    // Counter updates; the first match has no predecessor so gap_last stays put.
    always_comb begin
        cnt_d      = cnt_q;
        gap_cnt_d  = gap_cnt_q;
        gap_last_d = gap_last_q;
        ovf_d      = ovf_q;
        if (bus.clear) begin
            cnt_d      = '0;
            gap_cnt_d  = '0;
            gap_last_d = '0;
            ovf_d      = 1'b0;
        end else if (bus.ena) begin
            case (trk_q)
                TRK_EMPTY: begin
                    if (bus.match_in) begin
                        cnt_d     = CNT_W'(1);
                        gap_cnt_d = '0;
                    end
                end
                TRK_TRACK: begin
                    if (bus.match_in) begin
                        gap_last_d = (gap_cnt_q == GAP_MAX) ? GAP_MAX : gap_cnt_q + GAP_W'(1);
                        gap_cnt_d  = '0;
                        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                        else                  cnt_d = cnt_q + CNT_W'(1);
                    end else if (gap_cnt_q != GAP_MAX) begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Snapshot takes the pre-edge registered values, so a same-cycle match is excluded.
    seqdet_snap_shifter #(
        .W (CNT_W + GAP_W)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .ena       (bus.ena),
        .clear     (bus.clear),
        .load      (bus.snap_req),
        .din       ({cnt_q, gap_last_q}),
        .ser_out   (bus.ser_out),
        .ser_valid (bus.ser_valid),
        .busy      (bus.busy)
    );

    assign bus.match_count = cnt_q;
    assign bus.gap_last    = gap_last_q;
    assign bus.overflow    = ovf_q;
endmodule
